// File: rtl/diaosi_types_pkg.sv
// Shared types for the pipeline sequencer: FSM states, register selects
// and the packed latch-control word with a builder helper.
package diaosi_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } ctrl_state_t;

    // pipe_en[n] / flushed[n] map to pipeN_en / flushedN
    typedef struct packed {
        logic       pc_en;
        logic [4:1] pipe_en;
        logic [3:1] flushed;
    } ctrl_t;

    function automatic ctrl_t ctrl_word(
        input logic       pc,
        input logic [4:1] pipe,
        input logic [3:1] fl
    );
        ctrl_t c;
        c.pc_en   = pc;
        c.pipe_en = pipe;
        c.flushed = fl;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: EX holds a load whose destination feeds a DC source.
// Ports: ex_dren, ex_wsel, dc_rsel1, dc_rsel2 in; loaduse out.
module hazard_detect
    import diaosi_types_pkg::*;
(
    input  logic     ex_dren,
    input  regbits_t ex_wsel,
    input  regbits_t dc_rsel1,
    input  regbits_t dc_rsel2,
    output logic     loaduse
);

    // r0 is hardwired zero, so a load into it never creates a dependency
    assign loaduse = ex_dren
                   & (ex_wsel != '0)
                   & ((ex_wsel == dc_rsel1) | (ex_wsel == dc_rsel2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: latch enables,
// bubble flags, PC enable and halt.
module pipeline_ctrl
  import diaosi_types_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     ihit,
  input  logic     dhit,
  input  logic     mem_dreq,
  input  logic     mem_halt,
  input  logic     mem_redirect,
  input  logic     ex_dren,
  input  regbits_t ex_wsel,
  input  regbits_t dc_rsel1,
  input  regbits_t dc_rsel2,
  output logic     pc_en,
  output logic     pipe1_en,
  output logic     pipe2_en,
  output logic     pipe3_en,
  output logic     pipe4_en,
  output logic     flushed1,
  output logic     flushed2,
  output logic     flushed3,
  output logic     halt
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  ctrl_state_t state, state_n;
  logic        redir_hold, redir_n;
  logic        loaduse;
  logic        dwait;
  logic        live;
  ctrl_t       ctl;

  hazard_detect u_hazard (
    .ex_dren  (ex_dren),
    .ex_wsel  (ex_wsel),
    .dc_rsel1 (dc_rsel1),
    .dc_rsel2 (dc_rsel2),
    .loaduse  (loaduse)
  );

  assign dwait = mem_dreq & ~dhit;
  assign live  = (state == RUN)
               | (state == DWAIT);

  always_comb begin
    state_n = state;
    ctl     = ctrl_word(1'b0, 4'b0000, 3'b000);
    unique case (state)
      RUN, DWAIT: begin
        if (dwait) begin
          state_n = DWAIT;
        end else begin
          state_n = mem_halt ? DRAIN : RUN;
          if (mem_redirect)
            ctl = ctrl_word(1'b1, 4'b1111, 3'b111);
          else if (loaduse)
            ctl = ctrl_word(1'b0, 4'b1110, 3'b010);
          else if (!ihit)
            ctl = ctrl_word(1'b0, 4'b1111, 3'b001);
          else
            ctl = ctrl_word(1'b1, 4'b1111, 3'b000);
          if (redir_hold)
            ctl.flushed[1] = 1'b1;
        end
      end
      DRAIN: begin
        state_n = HALTED;
        ctl     = ctrl_word(1'b0, 4'b1111, 3'b111);
      end
      HALTED: begin
        state_n = HALTED;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  always_comb begin
    redir_n = redir_hold;
    if (ihit)
      redir_n = 1'b0;
    if (live && !dwait && mem_redirect && !ihit)
      redir_n = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RUN;
      redir_hold <= 1'b0;
      halt       <= 1'b0;
    end else begin
      state      <= state_n;
      redir_hold <= redir_n;
      halt       <= (state == HALTED);
    end
  end

  assign pc_en    = ctl.pc_en;
  assign pipe1_en = ctl.pipe_en[1];
  assign pipe2_en = ctl.pipe_en[2];
  assign pipe3_en = ctl.pipe_en[3];
  assign pipe4_en = ctl.pipe_en[4];
  assign flushed1 = ctl.flushed[1];
  assign flushed2 = ctl.flushed[2];
  assign flushed3 = ctl.flushed[3];

`ifdef PIPE_CTRL_PERF_EN
  logic stall_evt, flush_evt;

  assign stall_evt = live & (dwait
    | (~mem_redirect & (loaduse | ~ihit)));
  assign flush_evt = live & ~dwait
    & mem_redirect;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != HALTED) begin
      if (stall_evt && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl:
// random and directed stimulus vs model.
module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       ihit = 0, dhit = 0;
  logic       mem_dreq = 0, mem_halt = 0;
  logic       mem_redirect = 0, ex_dren = 0;
  logic [4:0] ex_wsel = 0;
  logic [4:0] dc_rsel1 = 0, dc_rsel2 = 0;
  logic       pc_en, pipe1_en, pipe2_en;
  logic       pipe3_en, pipe4_en;
  logic       flushed1, flushed2, flushed3;
  logic       halt;

  int checks = 0;
  int failures = 0;
  int phase = 0;

  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .ihit(ihit), .dhit(dhit),
    .mem_dreq(mem_dreq),
    .mem_halt(mem_halt),
    .mem_redirect(mem_redirect),
    .ex_dren(ex_dren),
    .ex_wsel(ex_wsel),
    .dc_rsel1(dc_rsel1),
    .dc_rsel2(dc_rsel2),
    .pc_en(pc_en),
    .pipe1_en(pipe1_en),
    .pipe2_en(pipe2_en),
    .pipe3_en(pipe3_en),
    .pipe4_en(pipe4_en),
    .flushed1(flushed1),
    .flushed2(flushed2),
    .flushed3(flushed3),
    .halt(halt)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt)
    , .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    bit       pc;
    bit [3:0] pipe;
    bit [2:0] fl;
    bit       hlt;
    int       st;
    int       fc;
    int       ph;
  } exp_t;

  exp_t sb[$];

  bit m_run = 1, m_drain = 0, m_stop = 0;
  bit m_hold = 0, m_halt = 0;
  int m_stall = 0, m_flush = 0;

  function automatic int sat(input int c);
`ifdef PIPE_CTRL_PERF_EN
    return (c > CMAX) ? CMAX : c;
`else
    return c;
`endif
  endfunction

  task automatic chk(input string nm,
                     input int act,
                     input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s phase=%0d actual=%0h required=%0h",
               nm, phase, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_run = 1; m_drain = 0; m_stop = 0;
    m_hold = 0; m_halt = 0;
    m_stall = 0; m_flush = 0;
  endtask

  task automatic cyc(input bit ih, dh, dq, mh, mr, er,
                     input int ew, r1, r2);
    exp_t e;
    bit dw, lu, was_stop;
    @(negedge CLK);
    ihit = ih; dhit = dh; mem_dreq = dq;
    mem_halt = mh;
    mem_redirect = mr; ex_dren = er;
    ex_wsel = 5'(ew);
    dc_rsel1 = 5'(r1); dc_rsel2 = 5'(r2);
    dw = dq && !dh;
    lu = er && (ew != 0) && (ew == r1 || ew == r2);
    e.pc = 0; e.pipe = 4'b0000; e.fl = 3'b000;
    e.hlt = m_halt;
    e.st = sat(m_stall); e.fc = sat(m_flush);
    e.ph = phase;
    if (m_drain) begin
      e.pipe = 4'b1111; e.fl = 3'b111;
    end else if (m_run && !dw) begin
      if (mr) begin
        e.pc = 1; e.pipe = 4'b1111; e.fl = 3'b111;
      end else if (lu) begin
        e.pipe = 4'b1110; e.fl = 3'b010;
      end else if (!ih) begin
        e.pipe = 4'b1111; e.fl = 3'b001;
      end else begin
        e.pc = 1; e.pipe = 4'b1111;
      end
      if (m_hold) e.fl[0] = 1;
    end
    sb.push_back(e);
    was_stop = m_stop;
    m_halt = was_stop;
    if (m_run) begin
      if (dw || (!mr && (lu || !ih))) m_stall++;
      if (!dw && mr) m_flush++;
    end
    if (ih) m_hold = 0;
    if (m_run && !dw && mr && !ih) m_hold = 1;
    if (m_drain) begin
      m_drain = 0; m_stop = 1;
    end else if (m_run && !dw && mh) begin
      m_run = 0; m_drain = 1;
    end
  endtask

  task automatic idle(input bit ih);
    cyc(ih, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_cyc(input bit allow_halt);
    cyc($urandom_range(3) != 0, $urandom_range(1),
        $urandom_range(9) < 3,
        allow_halt && ($urandom_range(1) == 1),
        $urandom_range(9) == 0, $urandom_range(9) < 4,
        $urandom_range(7), $urandom_range(7),
        $urandom_range(7));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #3;
    nRST = 0;
    model_reset();
    #1;
    chk("rst_halt", halt, 0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
`endif
    @(posedge CLK);
    #1;
    nRST = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_en", pc_en, e.pc);
        chk("pipe_en",
            {pipe4_en, pipe3_en, pipe2_en, pipe1_en},
            e.pipe);
        chk("flushed",
            {flushed3, flushed2, flushed1}, e.fl);
        chk("halt", halt, e.hlt);
`ifdef PIPE_CTRL_PERF_EN
        chk("stall_cnt", stall_cnt, e.st);
        chk("flush_cnt", flush_cnt, e.fc);
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout actual=running required=done");
    $fatal(1, "timeout");
  end

  initial begin : driver
    nRST = 0;
    #12;
    nRST = 1;
    #1;
    chk("reset_pc_en", pc_en, 0);
    chk("reset_pipe_en",
        {pipe4_en, pipe3_en, pipe2_en, pipe1_en}, 4'hf);
    chk("reset_flushed",
        {flushed3, flushed2, flushed1}, 3'b001);
    chk("reset_halt", halt, 0);

    phase = 1;
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(1);

    phase = 2;
    cyc(1, 0, 0, 0, 0, 1, 5, 3, 5);
    idle(1);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 7, 7, 2);

    phase = 3;
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(0);
    idle(0);
    idle(1);
    idle(1);

    phase = 4;
    cyc(1, 0, 0, 0, 1, 1, 5, 5, 0);
    cyc(0, 0, 0, 0, 1, 1, 4, 1, 4);
    idle(1);

    phase = 5;
    cyc(1, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0, 0, 0);
    idle(1);
    idle(1);
    do_reset();

    phase = 6;
    for (int i = 0; i < 400; i++) rnd_cyc(0);

    phase = 7;
    do_reset();
    for (int i = 0; i < 4; i++) idle(0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    #3;
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall4", stall_cnt, 4);
    chk("perf_flush2", flush_cnt, 2);
`endif
    do_reset();

    phase = 8;
    for (int i = 0; i < 20; i++) rnd_cyc(0);
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) rnd_cyc(1);
    #3;
    chk("halted_flag", halt, 1);
    chk("halted_pc_en", pc_en, 0);
    chk("halted_pipe_en",
        {pipe4_en, pipe3_en, pipe2_en, pipe1_en}, 0);

    phase = 9;
    do_reset();
    for (int i = 0; i < 30; i++) rnd_cyc(0);

    @(negedge CLK);
    #4;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the five-stage pipeline latches: every cycle it computes the latch enables and bubble-insert flags for IF/DC, DC/EX, EX/MEM and MEM/WB, plus the PC enable. It resolves memory waits, load-use hazards, control redirects and halt drain. It sits between the datapath hazard sources (cache hits, decoded register selects, resolved branch/jump) and the latch bank, and is the only driver of its `pipeN_en`/`flushedN` controls.

## Interface
Parameters
- `CNT_W`, default 32: width of performance counters (only with `PIPE_CTRL_PERF_EN`).

Ports
- `CLK` in 1: clock; rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `ihit` in 1: instruction fetch returned valid this cycle.
- `dhit` in 1: data access in MEM completed this cycle.
- `mem_dreq` in 1: MEM stage holds a load or store (`d_ren_o3 | d_wen_o3`).
- `mem_halt` in 1: MEM stage holds halt (`halt_o3`).
- `mem_redirect` in 1: taken branch, jump or jr resolved in MEM.
- `ex_dren` in 1: EX stage holds a load (`d_ren_o2`).
- `ex_wsel` in regbits_t: EX destination register.
- `dc_rsel1`, `dc_rsel2` in regbits_t: DC source registers.
- `pc_en` out 1: PC register update.
- `pipe1_en`..`pipe4_en` out 1 each: latch enables, IF/DC .. MEM/WB.
- `flushed1`..`flushed3` out 1 each: load bubble into IF/DC, DC/EX, EX/MEM.
- `halt` out 1: registered; core stopped.
- `stall_cnt`, `flush_cnt` out CNT_W: perf counters (macro only).

## Operation
- FSM `ctrl_state_t`: RUN, DWAIT, DRAIN, HALTED. Reset → RUN.
- Combinational hazards, evaluated in priority order:
  - dwait = `mem_dreq & ~dhit`. All `pipeN_en`, `pc_en` = 0; `flushedN` = 0. Go to DWAIT, or stay there, while dwait holds.
  - redirect = `mem_redirect`, applied when not dwait. All enables = 1 and `flushed1..3` = 1; the PC loads the target.
  - loaduse = `ex_dren & ex_wsel!=0 & (ex_wsel==dc_rsel1 | ex_wsel==dc_rsel2)`, applied when neither of the above. `pc_en` = 0, `pipe1_en` = 0, `pipe2..4_en` = 1, `flushed2` = 1.
  - imiss = `~ihit`, applied when none of the above. `pc_en` = 0, `pipe1..4_en` = 1, `flushed1` = 1.
  - None of the above: all enables = 1, all flushes = 0.
- Register `redir_hold`:
  - Set when redirect occurs while `ihit`=0, because the outstanding fetch is from the stale path.
  - While set, `flushed1` is forced to 1.
  - Cleared on the first cycle with `ihit`=1.
- Halt:
  - In RUN, `mem_halt` with no dwait → DRAIN.
  - In DRAIN: `pc_en` = 0, `pipe1..3_en` = 1, `flushed1..3` = 1, `pipe4_en` = 1. This lets the instruction ahead of the halt retire through WB.
  - The next cycle → HALTED.
- HALTED: every enable = 0 and `halt` = 1. HALTED is sticky until `nRST`.
- DWAIT → RUN on `dhit`; that cycle follows the RUN rules above.
- Reset mid-operation clears the state, `redir_hold`, `halt` and the counters immediately.

## Timing
- Enables and flushes are combinational from inputs, state and `redir_hold`, with zero-cycle latency; the latches sample them on the same edge.
- Reset values:
  - State RUN, `redir_hold` 0, `halt` 0, counters 0.
  - With all inputs 0 and `ihit`=0, outputs are `pc_en` 0, `pipe1..4_en` 1, `flushed1` 1, `flushed2..3` 0.
- `halt` rises one edge after entering HALTED, which is two edges after `mem_halt` is sampled in RUN.
- Redirect coinciding with loaduse or imiss: redirect wins, and the load-use bubble is discarded with the flushed stage.
- `mem_halt` together with dwait: stay in DWAIT; the halt is acted on once `dhit` arrives.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cnt` increments on each cycle with dwait, loaduse or imiss.
  - `flush_cnt` increments on each redirect.
  - Both saturate at all-ones and freeze in HALTED.
- Undefined: the counters and their ports are absent, and the control behaviour is identical.

## Structure
- `ctrl_state_t` enum goes in `diaosi_types_pkg`.
- Sub-module `hazard_detect`: purely combinational; computes loaduse from the EX/DC fields and is instanced once.

## Test plan
- `mem_dreq`=1, `dhit`=0 for 3 cycles, then 1 → all enables 0 for 3 cycles; on the 4th cycle all enables 1 and the state is RUN.
- `ex_dren`=1, `ex_wsel`=5, `dc_rsel2`=5, `ihit`=1 → `pc_en`=0, `pipe1_en`=0, `flushed2`=1 for exactly one cycle. With `ex_wsel`=0, no stall.
- `mem_redirect`=1 with `ihit`=0, then `ihit` low 2 more cycles → `flushed1`=1 on all 3 cycles; first cycle with `ihit`=1 has `flushed1`=1, next cycle 0.
- `mem_redirect` and loaduse in the same cycle → `flushed1..3`=1, `pc_en`=1, `flushed2` is not treated as a stall.
- `mem_halt`=1 in RUN → DRAIN for one cycle, then `halt`=1, and all enables stay 0 for 10 cycles regardless of inputs.
- Perf: 4 imiss cycles and 2 redirects → `stall_cnt`=4, `flush_cnt`=2. Assert `nRST` mid-run → both 0 asynchronously.
